// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry instruction register with valid/ready,
// and in-stage resolution of jmp/br so control flow never reaches execute.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              exec_busy,
    input  logic              zero_flag,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    // state     | meaning
    // ST_FETCH   | consume one ROM word per cycle whenever the IR slot is free
    // ST_BR_WAIT | br seen; wait for IR and execute to drain, then resolve
    // ST_HALT    | opcode 0000 seen; frozen until reset
    typedef enum logic [1:0] {ST_FETCH, ST_BR_WAIT, ST_HALT} state_t;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1100;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                halted_q, halted_d;
    logic                slot_free;
    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   rom_tgt;

    assign opcode    = rom_data[15:12];
    assign rom_tgt   = ADDR_W'(rom_data[11:8]);
    assign slot_free = ~ir_valid_q | ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        halted_d   = halted_q;
        // A handshake drains the slot in every state; a new issue overrides below.
        ir_valid_d = ir_valid_q & ~ir_ready;

        case (state_q)
            ST_FETCH: begin
                if (slot_free) begin
                    case (opcode)
                        OP_JMP: pc_d = rom_tgt;
                        OP_BR: begin
                            state_d = ST_BR_WAIT;
                            tgt_d   = rom_tgt;
                        end
                        OP_HALT: begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
                        default: begin
                            ir_d       = rom_data;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            pc_d       = pc_q + ADDR_W'(1);
                        end
                    endcase
                end
            end
            ST_BR_WAIT: begin
                // zero_flag only reflects all older instructions once both are empty.
                if (!ir_valid_q && !exec_busy) begin
                    pc_d    = zero_flag ? tgt_q : pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            tgt_q      <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random programs
// compared against a program-walk model of the issued instruction stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [3:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        exec_busy;
    logic        zero_flag;
    logic        halted;
    logic [3:0]  pc;

    logic [15:0] rom [16];
    bit          zf_tab [16];
    logic [3:0]  exp_pc_q [$];
    logic [15:0] exp_ins_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    fetch_unit #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .exec_busy(exec_busy), .zero_flag(zero_flag), .halted(halted), .pc(pc)
    );

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir_ready = 1'b1; exec_busy = 1'b0; zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rst_n = 1'b0; ir_ready = 1'b1; exec_busy = 1'b0; zero_flag = 1'b0;
        #1;
        checks++;
        if ({pc, ir, ir_pc, ir_valid, halted} !== 26'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%h ir=%h ir_pc=%h v=%b h=%b, required all 0", pc, ir, ir_pc, ir_valid, halted);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        // ROM all zero: address 0 is a halt
        checks++;
        if (halted !== 1'b1 || pc !== 4'd0 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_at_zero: h=%b pc=%0d v=%b, required h=1 pc=0 v=0", halted, pc, ir_valid);
        end
    endtask

    task automatic test_straight_line();
        clear_rom();
        rom[0] = 16'h1E07; rom[1] = 16'hFE00; rom[2] = 16'h0000;
        do_reset();
        @(negedge clk);
        checks++;
        if (ir !== 16'h1E07 || ir_pc !== 4'd0 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL straight_first: ir=%h ir_pc=%0d v=%b, required 1e07/0/1", ir, ir_pc, ir_valid);
        end
        @(negedge clk);
        checks++;
        if (ir !== 16'hFE00 || ir_pc !== 4'd1 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL straight_second: ir=%h ir_pc=%0d v=%b, required fe00/1/1", ir, ir_pc, ir_valid);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 4'd2) begin
            errors++;
            $display("FAIL straight_halt: h=%b v=%b pc=%0d, required 1/0/2", halted, ir_valid, pc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 4'd2) begin
            errors++;
            $display("FAIL straight_frozen: h=%b v=%b pc=%0d, required 1/0/2", halted, ir_valid, pc);
        end
    endtask

    task automatic test_jump();
        clear_rom();
        rom[0] = 16'h8500; rom[5] = 16'hFE00;
        do_reset();
        @(negedge clk);
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd5) begin
            errors++;
            $display("FAIL jump_bubble: v=%b pc=%0d, required v=0 pc=5", ir_valid, pc);
        end
        @(negedge clk);
        checks++;
        if (ir !== 16'hFE00 || ir_pc !== 4'd5 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL jump_target: ir=%h ir_pc=%0d v=%b, required fe00/5/1", ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_branch(input bit zf);
        logic [3:0] exp_pc;
        exp_pc = zf ? 4'd10 : 4'd4;
        clear_rom();
        rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003; rom[3] = 16'hCA00;
        rom[4] = 16'h1004; rom[10] = 16'h100A;
        do_reset();
        repeat (3) @(negedge clk);
        exec_busy = 1'b1;
        zero_flag = ~zf;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== 4'd3 || ir_valid !== 1'b0) begin
                errors++;
                $display("FAIL branch_hold[%0d]: pc=%0d v=%b, required pc=3 v=0", i, pc, ir_valid);
            end
        end
        exec_busy = 1'b0;
        zero_flag = zf;
        @(negedge clk);
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL branch_resolve zf=%0d: pc=%0d, required %0d", zf, pc, exp_pc);
        end
        @(negedge clk);
        checks++;
        if (ir_pc !== exp_pc || ir !== rom[exp_pc] || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_issue zf=%0d: ir=%h ir_pc=%0d v=%b, required %h/%0d/1", zf, ir, ir_pc, ir_valid, rom[exp_pc], exp_pc);
        end
    endtask

    task automatic test_backpressure();
        clear_rom();
        for (int i = 0; i < 6; i++) rom[i] = 16'h3000 + 16'(i);
        do_reset();
        ir_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ir !== 16'h3000 || ir_pc !== 4'd0 || pc !== 4'd1 || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_stable[%0d]: ir=%h ir_pc=%0d pc=%0d v=%b, required 3000/0/1/1", i, ir, ir_pc, pc, ir_valid);
            end
        end
        ir_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ir !== 16'h3001 || ir_pc !== 4'd1 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_no_bubble: ir=%h ir_pc=%0d v=%b, required 3001/1/1", ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = 16'h8F00; rom[15] = 16'h2280;
        do_reset();
        @(negedge clk);
        rom[0] = 16'hFE00;
        @(negedge clk);
        checks++;
        if (ir_pc !== 4'd15 || ir !== 16'h2280 || pc !== 4'd0) begin
            errors++;
            $display("FAIL wrap_15: ir=%h ir_pc=%0d pc=%0d, required 2280/15/0", ir, ir_pc, pc);
        end
        @(negedge clk);
        checks++;
        if (ir_pc !== 4'd0 || ir !== 16'hFE00 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_0: ir=%h ir_pc=%0d v=%b, required fe00/0/1", ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_reset_mid_branch();
        clear_rom();
        rom[0] = 16'h1234; rom[1] = 16'hC500;
        do_reset();
        exec_busy = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 4'd1 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_branch_entry: pc=%0d v=%b, required pc=1 v=0", pc, ir_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, ir, ir_pc, ir_valid, halted} !== 26'd0) begin
            errors++;
            $display("FAIL mid_branch_async: pc=%h ir=%h ir_pc=%h v=%b h=%b, required all 0", pc, ir, ir_pc, ir_valid, halted);
        end
        @(negedge clk);
        exec_busy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir !== 16'h1234 || ir_pc !== 4'd0 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_branch_restart: ir=%h ir_pc=%0d v=%b, required 1234/0/1", ir, ir_pc, ir_valid);
        end
    endtask

    // Architectural walk of the program: which words get issued, and where it halts.
    task automatic build_expected(output logic [3:0] halt_pc);
        logic [3:0]  p;
        logic [15:0] w;
        exp_pc_q.delete();
        exp_ins_q.delete();
        p = 4'd0;
        halt_pc = 4'd0;
        for (int step = 0; step < 64; step++) begin
            w = rom[p];
            if (w[15:12] == 4'h0) begin
                halt_pc = p;
                break;
            end else if (w[15:12] == 4'h8) begin
                p = w[11:8];
            end else if (w[15:12] == 4'hC) begin
                p = zf_tab[p] ? w[11:8] : p + 4'd1;
            end else begin
                exp_pc_q.push_back(p);
                exp_ins_q.push_back(w);
                p = p + 4'd1;
            end
        end
    endtask

    task automatic gen_program();
        logic [3:0] op;
        int unsigned r;
        for (int a = 0; a < 15; a++) begin
            r = $urandom_range(0, 11);
            zf_tab[a] = 1'($urandom_range(0, 1));
            if (r == 0) begin
                rom[a] = 16'h0000;
            end else if (r <= 2) begin
                rom[a] = {4'h8, 4'($urandom_range(a + 1, 15)), 8'($urandom)};
            end else if (r <= 4) begin
                rom[a] = {4'hC, 4'($urandom_range(a + 1, 15)), 8'($urandom)};
            end else begin
                do op = 4'($urandom_range(1, 15)); while (op == 4'h8 || op == 4'hC);
                rom[a] = {op, 12'($urandom)};
            end
        end
        rom[15] = 16'h0000;
        zf_tab[15] = 1'b0;
    endtask

    task automatic test_random(input int n_prog);
        logic [3:0]  halt_pc;
        logic [15:0] prev_ir;
        logic [3:0]  prev_ir_pc;
        bit          prev_stall;
        bit          done;
        for (int k = 0; k < n_prog; k++) begin
            gen_program();
            build_expected(halt_pc);
            do_reset();
            prev_stall = 1'b0;
            prev_ir = '0;
            prev_ir_pc = '0;
            done = 1'b0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                if (prev_stall) begin
                    checks++;
                    if (ir !== prev_ir || ir_pc !== prev_ir_pc || ir_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_stall prog %0d: ir=%h ir_pc=%0d v=%b, required %h/%0d/1", k, ir, ir_pc, ir_valid, prev_ir, prev_ir_pc);
                    end
                end
                if (halted && !ir_valid) begin
                    done = 1'b1;
                    break;
                end
                ir_ready  = ($urandom_range(0, 3) != 0);
                exec_busy = ($urandom_range(0, 2) == 0);
                zero_flag = exec_busy ? 1'($urandom_range(0, 1)) : zf_tab[pc];
                if (ir_valid && ir_ready) begin
                    checks++;
                    if (exp_pc_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra prog %0d: issued ir=%h ir_pc=%0d, required no further issue", k, ir, ir_pc);
                    end else begin
                        if (ir !== exp_ins_q[0] || ir_pc !== exp_pc_q[0]) begin
                            errors++;
                            $display("FAIL rand_issue prog %0d: ir=%h ir_pc=%0d, required %h/%0d", k, ir, ir_pc, exp_ins_q[0], exp_pc_q[0]);
                        end
                        void'(exp_pc_q.pop_front());
                        void'(exp_ins_q.pop_front());
                    end
                end
                prev_stall = ir_valid && !ir_ready;
                prev_ir = ir;
                prev_ir_pc = ir_pc;
            end
            checks++;
            if (!done || exp_pc_q.size() != 0 || pc !== halt_pc) begin
                errors++;
                $display("FAIL rand_end prog %0d: done=%0d left=%0d pc=%0d, required done=1 left=0 pc=%0d", k, done, exp_pc_q.size(), pc, halt_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_jump();
        test_branch(1'b1);
        test_branch(1'b0);
        test_backpressure();
        test_wrap();
        test_reset_mid_branch();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
